// File: rtl/div_sqrt_fn_issue_if.sv
// Handshake bundle between the div/sqrt issue block, its client and the div/sqrt unit.
//   req*  : client request channel (valid/ready), tagged operands
//   unit* : issue channel into the unit (inValid/inReady) and its one-cycle result pulse
//   resp* : tagged response channel back to the client (valid/ready)
// Modports:
//   slave  - the issue block (div_sqrt_fn_issue)
//   master - the surroundings: client plus unit
interface div_sqrt_fn_issue_if #(
    parameter int unsigned expWidth = 8,
    parameter int unsigned sigWidth = 24,
    parameter int unsigned tagWidth = 4
);
    localparam int unsigned FW = expWidth + sigWidth;

    logic                reqValid;
    logic                reqReady;
    logic                reqSqrtOp;
    logic [FW-1:0]       reqA;
    logic [FW-1:0]       reqB;
    logic [2:0]          reqRoundingMode;
    logic [tagWidth-1:0] reqTag;

    logic                unitInReady;
    logic                unitInValid;
    logic                unitSqrtOp;
    logic [FW-1:0]       unitA;
    logic [FW-1:0]       unitB;
    logic [2:0]          unitRoundingMode;
    logic                unitOutValid;
    logic                unitSqrtOpOut;
    logic [FW-1:0]       unitOut;
    logic [4:0]          unitExceptionFlags;

    logic                respValid;
    logic                respReady;
    logic                respSqrtOp;
    logic [FW-1:0]       respOut;
    logic [4:0]          respFlags;
    logic [tagWidth-1:0] respTag;

    modport slave (
        input  reqValid, reqSqrtOp, reqA, reqB, reqRoundingMode, reqTag,
        output reqReady,
        input  unitInReady, unitOutValid, unitSqrtOpOut, unitOut, unitExceptionFlags,
        output unitInValid, unitSqrtOp, unitA, unitB, unitRoundingMode,
        input  respReady,
        output respValid, respSqrtOp, respOut, respFlags, respTag
    );

    modport master (
        output reqValid, reqSqrtOp, reqA, reqB, reqRoundingMode, reqTag,
        input  reqReady,
        output unitInReady, unitOutValid, unitSqrtOpOut, unitOut, unitExceptionFlags,
        input  unitInValid, unitSqrtOp, unitA, unitB, unitRoundingMode,
        output respReady,
        input  respValid, respSqrtOp, respOut, respFlags, respTag
    );
endinterface

// File: rtl/div_sqrt_resp_fifo.sv
// Small synchronous FIFO holding completed div/sqrt results.
// Ports:
//   clk_i, rst_ni   - clock, asynchronous active-low reset (empties the FIFO)
//   push_i, data_i  - write side; a push into a full FIFO is only taken with a same-cycle pop
//   pop_i, data_o   - read side; data_o is the head entry, valid while !empty_o
//   empty_o, full_o - occupancy flags
//   count_o         - number of stored entries
module div_sqrt_resp_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 2,
    parameter int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CntW-1:0]  count_o
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    // Pointers wrap at Depth, which need not be a power of two.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(Depth));
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CntW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once the count says they were written.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end
endmodule

// File: rtl/div_sqrt_fn_issue.sv
// Initiator/collector for the standard-format divide/sqrt unit.
// Takes one tagged request at a time from the client, issues it to the unit from registered
// operands, catches the unit's non-stallable result pulse into a response FIFO and returns
// tagged results to the client. A FIFO slot is reserved before every issue so no result is lost.
// Ports:
//   clock, nReset - clock, asynchronous active-low reset
//   control       - unit control word, passed straight through to unitControl
//   unitControl   - control word towards the unit
//   strayResult   - sticky flag: a result pulse arrived while no operation was outstanding
//   bus           - req/unit/resp handshake bundle (slave side)
`ifndef floatControlWidth
`define floatControlWidth 1
`endif

module div_sqrt_fn_issue #(
    parameter int unsigned expWidth  = 8,
    parameter int unsigned sigWidth  = 24,
    parameter int unsigned tagWidth  = 4,
    parameter int unsigned respDepth = 2
) (
    input  logic                          clock,
    input  logic                          nReset,
    input  logic [`floatControlWidth-1:0] control,
    output logic [`floatControlWidth-1:0] unitControl,
    output logic                          strayResult,
    div_sqrt_fn_issue_if.slave            bus
);
    localparam int unsigned FW     = expWidth + sigWidth;
    localparam int unsigned EntryW = 1 + FW + 5 + tagWidth;
    localparam int unsigned CntW   = $clog2(respDepth + 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                sqrt_op_q, sqrt_op_d;
    logic [FW-1:0]       a_q, a_d;
    logic [FW-1:0]       b_q, b_d;
    logic [2:0]          rm_q, rm_d;
    logic [tagWidth-1:0] tag_q, tag_d;
    logic                stray_q, stray_d;

    logic [CntW-1:0]     fifo_count;
    logic                fifo_empty, fifo_full;
    logic                fifo_push, fifo_pop;
    logic [EntryW-1:0]   push_data, pop_data;
    logic                credit_ok, req_fire;

    assign fifo_pop = !fifo_empty && bus.respReady;

    // Only IDLE accepts, and nothing is pushed in IDLE, so a free slot now stays free until the
    // result of this request arrives. A pop in this cycle already counts as a free slot.
    assign credit_ok    = (fifo_count < CntW'(respDepth)) || fifo_pop;
    assign bus.reqReady = nReset && (state_q == StIdle) && credit_ok;
    assign req_fire     = bus.reqValid && bus.reqReady;

    always_comb begin
        state_d   = state_q;
        sqrt_op_d = sqrt_op_q;
        a_d       = a_q;
        b_d       = b_q;
        rm_d      = rm_q;
        tag_d     = tag_q;
        unique case (state_q)
            StIdle: begin
                if (req_fire) begin
                    sqrt_op_d = bus.reqSqrtOp;
                    a_d       = bus.reqA;
                    b_d       = bus.reqB;
                    rm_d      = bus.reqRoundingMode;
                    tag_d     = bus.reqTag;
                    state_d   = StIssue;
                end
            end
            StIssue: begin
                if (bus.unitInReady) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (bus.unitOutValid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A result pulse with nothing outstanding is dropped and flagged until reset.
    assign stray_d   = stray_q || (bus.unitOutValid && (state_q != StWait));
    assign fifo_push = (state_q == StWait) && bus.unitOutValid;
    assign push_data = {bus.unitSqrtOpOut, bus.unitOut, bus.unitExceptionFlags, tag_q};

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state_q   <= StIdle;
            sqrt_op_q <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            rm_q      <= '0;
            tag_q     <= '0;
            stray_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sqrt_op_q <= sqrt_op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rm_q      <= rm_d;
            tag_q     <= tag_d;
            stray_q   <= stray_d;
        end
    end

    div_sqrt_resp_fifo #(
        .Width (EntryW),
        .Depth (respDepth),
        .CntW  (CntW)
    ) u_resp_fifo (
        .clk_i   (clock),
        .rst_ni  (nReset),
        .push_i  (fifo_push),
        .data_i  (push_data),
        .pop_i   (fifo_pop),
        .data_o  (pop_data),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    assign bus.unitInValid      = (state_q == StIssue);
    assign bus.unitSqrtOp       = sqrt_op_q;
    assign bus.unitA            = a_q;
    assign bus.unitB            = b_q;
    assign bus.unitRoundingMode = rm_q;

    assign bus.respValid = !fifo_empty;
    assign {bus.respSqrtOp, bus.respOut, bus.respFlags, bus.respTag} = pop_data;

    assign unitControl = control;
    assign strayResult = stray_q;

    // The full flag is implied by the count comparison above.
    logic unused_full;
    assign unused_full = fifo_full;
endmodule

// File: tb/tb_div_sqrt_fn_issue.sv
`ifndef floatControlWidth
`define floatControlWidth 1
`endif

module tb_div_sqrt_fn_issue;
    localparam int unsigned ExpW  = 8;
    localparam int unsigned SigW  = 24;
    localparam int unsigned TagW  = 4;
    localparam int unsigned Depth = 2;
    localparam int unsigned FW    = ExpW + SigW;

    typedef struct packed {
        logic            op;
        logic [FW-1:0]   a;
        logic [FW-1:0]   b;
        logic [2:0]      rm;
        logic [TagW-1:0] tag;
    } req_t;

    typedef struct packed {
        logic            op;
        logic [FW-1:0]   out;
        logic [4:0]      flags;
        logic [TagW-1:0] tag;
    } resp_t;

    logic                          clock = 1'b0;
    logic                          nReset;
    logic [`floatControlWidth-1:0] control;
    logic [`floatControlWidth-1:0] unitControl;
    logic                          strayResult;

    div_sqrt_fn_issue_if #(.expWidth(ExpW), .sigWidth(SigW), .tagWidth(TagW)) bus ();

    div_sqrt_fn_issue #(
        .expWidth  (ExpW),
        .sigWidth  (SigW),
        .tagWidth  (TagW),
        .respDepth (Depth)
    ) dut (
        .clock       (clock),
        .nReset      (nReset),
        .control     (control),
        .unitControl (unitControl),
        .strayResult (strayResult),
        .bus         (bus)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behaviour of the divide/sqrt unit as seen by this bench: fixed results for the known
    // operand pairs, an arbitrary but deterministic mix for everything else.
    function automatic logic [FW+4:0] unit_fn(input logic op, input logic [FW-1:0] a,
                                              input logic [FW-1:0] b);
        if (!op && a == 32'h3F80_0000 && b == 32'h4000_0000) return {32'h3F00_0000, 5'b00000};
        if (op && a == 32'h4080_0000) return {32'h4000_0000, 5'b00000};
        if (!op && b == '0) return {32'h7F80_0000, 5'b01000};
        return {a ^ {b[15:0], b[31:16]} ^ {31'b0, op}, a[4:0] ^ b[9:5]};
    endfunction

    function automatic resp_t make_resp(input req_t r);
        logic [FW+4:0] res;
        res = unit_fn(r.op, r.a, r.b);
        return {r.op, res[FW+4:5], res[4:0], r.tag};
    endfunction

    // ---------------- reference model ----------------
    // Phase 0: no operation held, 1: offered to the unit, 2: waiting for the result pulse.
    req_t  m_cur;
    resp_t mq[$];
    int    m_cnt;
    int    m_phase;
    logic  m_stray;
    logic  exp_ready;

    always_comb begin
        exp_ready = (m_phase == 0) && ((m_cnt < Depth) || (m_cnt > 0 && bus.respReady));
    end

    always @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            m_phase <= 0;
            m_cnt   <= 0;
            m_stray <= 1'b0;
            m_cur   <= '0;
            mq.delete();
        end else begin
            if (m_cnt > 0 && bus.respReady) void'(mq.pop_front());
            if (m_phase == 2 && bus.unitOutValid) mq.push_back(make_resp(m_cur));
            m_cnt <= m_cnt + ((m_phase == 2 && bus.unitOutValid) ? 1 : 0)
                           - ((m_cnt > 0 && bus.respReady) ? 1 : 0);
            m_stray <= m_stray | (bus.unitOutValid && m_phase != 2);
            case (m_phase)
                0: if (bus.reqValid && exp_ready) begin
                    m_cur   <= {bus.reqSqrtOp, bus.reqA, bus.reqB, bus.reqRoundingMode, bus.reqTag};
                    m_phase <= 1;
                end
                1: if (bus.unitInReady) m_phase <= 2;
                default: if (bus.unitOutValid) m_phase <= 0;
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        if (nReset && chk_en) begin
            check("reqReady", bus.reqReady, exp_ready);
            check("unitInValid", bus.unitInValid, m_phase == 1);
            if (m_phase == 1) begin
                check("unitSqrtOp", bus.unitSqrtOp, m_cur.op);
                check("unitA", bus.unitA, m_cur.a);
                check("unitB", bus.unitB, m_cur.b);
                check("unitRoundingMode", bus.unitRoundingMode, m_cur.rm);
            end
            check("respValid", bus.respValid, m_cnt > 0);
            if (m_cnt > 0 && mq.size() > 0) begin
                check("respSqrtOp", bus.respSqrtOp, mq[0].op);
                check("respOut", bus.respOut, mq[0].out);
                check("respFlags", bus.respFlags, mq[0].flags);
                check("respTag", bus.respTag, mq[0].tag);
            end
            check("strayResult", strayResult, m_stray);
            check("unitControl", unitControl, control);
        end
    end

    // ---------------- stimulus: client and unit ----------------
    req_t          req_q[$];
    bit            presenting = 1'b0;
    bit            gap_mode   = 1'b0;
    bit            hold_in    = 1'b0;
    bit            inject_stray = 1'b0;
    int            resp_mode  = 1;
    int            lat        = 0;
    logic          u_op;
    logic [FW-1:0] u_a, u_b;

    // One clock: sample handshakes at the negedge, drive the next cycle's inputs #1 after posedge.
    task automatic tick();
        logic          fire;
        logic          ihs;
        logic [FW+4:0] res;
        @(negedge clock);
        fire = bus.reqValid && bus.reqReady;
        ihs  = bus.unitInValid && bus.unitInReady;
        if (ihs) begin
            u_op = bus.unitSqrtOp;
            u_a  = bus.unitA;
            u_b  = bus.unitB;
            lat  = $urandom_range(1, 4);
        end
        @(posedge clock);
        #1;
        if (fire && req_q.size() > 0) begin
            void'(req_q.pop_front());
            presenting = 1'b0;
        end
        bus.unitOutValid = 1'b0;
        if (lat > 0) begin
            lat--;
            if (lat == 0) begin
                res                    = unit_fn(u_op, u_a, u_b);
                bus.unitOutValid       = 1'b1;
                bus.unitSqrtOpOut      = u_op;
                bus.unitOut            = res[FW+4:5];
                bus.unitExceptionFlags = res[4:0];
            end
        end else if (inject_stray) begin
            bus.unitOutValid       = 1'b1;
            bus.unitSqrtOpOut      = 1'b1;
            bus.unitOut            = 32'hDEAD_BEEF;
            bus.unitExceptionFlags = 5'h1F;
            inject_stray           = 1'b0;
        end
        bus.unitInReady = hold_in ? 1'b0 : ($urandom_range(0, 3) != 0);
        case (resp_mode)
            0:       bus.respReady = 1'b0;
            1:       bus.respReady = 1'b1;
            default: bus.respReady = ($urandom_range(0, 2) != 0);
        endcase
        if (req_q.size() > 0 && (presenting || !gap_mode || $urandom_range(0, 1) == 1)) begin
            bus.reqValid        = 1'b1;
            bus.reqSqrtOp       = req_q[0].op;
            bus.reqA            = req_q[0].a;
            bus.reqB            = req_q[0].b;
            bus.reqRoundingMode = req_q[0].rm;
            bus.reqTag          = req_q[0].tag;
            presenting          = 1'b1;
        end else begin
            bus.reqValid = 1'b0;
            bus.reqA     = $urandom;
        end
        control = `floatControlWidth'($urandom);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (n < 2000 && (req_q.size() > 0 || m_phase != 0 || m_cnt != 0 || lat != 0)) begin
            tick();
            n++;
        end
        if (n >= 2000) check({name, "_drain_timeout"}, 0, 1);
    endtask

    task automatic run_op(input string name, input logic op, input logic [FW-1:0] a,
                          input logic [FW-1:0] b, input logic [TagW-1:0] tag,
                          input logic [FW-1:0] exp_out, input logic [4:0] exp_flags,
                          input bit hold);
        int n;
        bit got;
        req_q.push_back({op, a, b, 3'd1, tag});
        hold_in = hold;
        if (hold) begin
            n = 0;
            while (n < 50 && bus.unitInValid !== 1'b1) begin
                tick();
                #1;
                n++;
            end
            for (int i = 0; i < 4; i++) begin
                check({name, "_hold_valid"}, bus.unitInValid, 1);
                check({name, "_hold_a"}, bus.unitA, a);
                check({name, "_hold_op"}, bus.unitSqrtOp, op);
                tick();
                #1;
            end
            hold_in = 1'b0;
        end
        n   = 0;
        got = 1'b0;
        while (n < 200 && !got) begin
            tick();
            #1;
            n++;
            if (bus.respValid === 1'b1) begin
                got = 1'b1;
                check({name, "_out"}, bus.respOut, exp_out);
                check({name, "_flags"}, bus.respFlags, exp_flags);
                check({name, "_tag"}, bus.respTag, tag);
                check({name, "_op"}, bus.respSqrtOp, op);
            end
        end
        if (!got) check({name, "_timeout"}, 0, 1);
        drain(name);
    endtask

    initial begin
        int n;
        bus.reqValid = 1'b0; bus.reqSqrtOp = 1'b0; bus.reqA = '0; bus.reqB = '0;
        bus.reqRoundingMode = '0; bus.reqTag = '0;
        bus.unitInReady = 1'b0; bus.unitOutValid = 1'b0; bus.unitSqrtOpOut = 1'b0;
        bus.unitOut = '0; bus.unitExceptionFlags = '0; bus.respReady = 1'b1;
        control = '0;
        nReset = 1'b1;
        #1 nReset = 1'b0;
        #1;
        check("rst_reqReady", bus.reqReady, 0);
        check("rst_unitInValid", bus.unitInValid, 0);
        check("rst_respValid", bus.respValid, 0);
        check("rst_strayResult", strayResult, 0);
        repeat (3) @(posedge clock);
        #1 nReset = 1'b1;
        chk_en = 1'b1;

        run_op("div", 1'b0, 32'h3F80_0000, 32'h4000_0000, 4'd3, 32'h3F00_0000, 5'b00000, 1'b0);
        run_op("sqrt", 1'b1, 32'h4080_0000, 32'h0, 4'd5, 32'h4000_0000, 5'b00000, 1'b1);
        run_op("divzero", 1'b0, 32'h3F80_0000, 32'h0, 4'd7, 32'h7F80_0000, 5'b01000, 1'b0);

        // Backpressure: two results fill the FIFO, the third request must wait for a pop.
        resp_mode = 0;
        bus.respReady = 1'b0;
        req_q.push_back({1'b0, 32'h4040_0000, 32'h3F80_0000, 3'd0, 4'd1});
        req_q.push_back({1'b1, 32'h4110_0000, 32'h0000_0000, 3'd2, 4'd2});
        req_q.push_back({1'b0, 32'h3F80_0000, 32'h4000_0000, 3'd4, 4'd3});
        n = 0;
        while (n < 300 && m_cnt < 2) begin
            tick();
            n++;
        end
        #1;
        check("bp_full_reqReady", bus.reqReady, 0);
        check("bp_third_stalled", req_q.size(), 1);
        check("bp_head_tag", bus.respTag, 1);
        resp_mode = 1;
        bus.respReady = 1'b1;
        #1;
        check("bp_pop_frees_slot", bus.reqReady, 1);
        check("bp_first_tag", bus.respTag, 1);
        tick();
        #1;
        check("bp_second_tag", bus.respTag, 2);
        check("bp_third_issued", bus.unitInValid, 1);
        drain("bp");

        // Randomized traffic with client gaps and response backpressure.
        resp_mode = 2;
        gap_mode  = 1'b1;
        for (int i = 0; i < 200; i++) begin
            req_q.push_back({1'($urandom), 32'($urandom),
                             ($urandom_range(0, 15) == 0) ? 32'h0 : 32'($urandom),
                             3'($urandom), 4'($urandom)});
        end
        n = 0;
        while (n < 20000 && (req_q.size() > 0 || m_phase != 0 || m_cnt != 0 || lat != 0)) begin
            tick();
            n++;
        end
        if (n >= 20000) check("rand_timeout", 0, 1);
        resp_mode = 1;
        gap_mode  = 1'b0;
        repeat (3) tick();

        // Result pulse with nothing outstanding: dropped, flagged until reset.
        inject_stray = 1'b1;
        tick();
        tick();
        #1;
        check("stray_set", strayResult, 1);
        check("stray_no_push", bus.respValid, 0);
        repeat (3) tick();
        #1;
        check("stray_sticky", strayResult, 1);

        // Reset while waiting for the unit.
        req_q.push_back({1'b0, 32'h4000_0000, 32'h4000_0000, 3'd0, 4'd6});
        n = 0;
        while (n < 200 && m_phase != 2) begin
            tick();
            n++;
        end
        if (n >= 200) check("rstmid_reach_wait", 0, 1);
        nReset = 1'b0;
        lat = 0;
        req_q.delete();
        presenting = 1'b0;
        bus.reqValid = 1'b0;
        bus.unitOutValid = 1'b0;
        #1;
        check("rstmid_reqReady", bus.reqReady, 0);
        check("rstmid_unitInValid", bus.unitInValid, 0);
        check("rstmid_respValid", bus.respValid, 0);
        check("rstmid_strayResult", strayResult, 0);
        repeat (2) tick();
        nReset = 1'b1;
        run_op("post_rst", 1'b0, 32'h3F80_0000, 32'h4000_0000, 4'd9, 32'h3F00_0000, 5'b00000,
               1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
